// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared definitions for the gate BIST sequencer.
// Holds the op encoding, FSM state type and MISR polynomial/step helper.
package gate_bist_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One MISR shift: shift left, fold in the polynomial on carry-out, xor new data.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
    endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// gate_ref: combinational reference for the two-input gate family.
// Produces the bitwise result of the selected op; reusable by ALU benches.
module gate_ref
    import gate_bist_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] exp
);

    // Select the expected gate function for the captured opcode.
    always_comb begin
        exp = a;
        case (op)
            OP_AND:  exp = a & b;
            OP_OR:   exp = a | b;
            OP_NAND: exp = ~(a & b);
            OP_NOR:  exp = ~(a | b);
            OP_XOR:  exp = a ^ b;
            OP_XNOR: exp = ~(a ^ b);
            OP_NOTA: exp = ~a;
            default: exp = a;
        endcase
    end

endmodule

// File: rtl/gate_bist.sv
// gate_bist: exhaustive BIST sequencer wrapped around one two-input gate.
// Walks every {a,b} vector, holds each SETTLE cycles, compares once, and
// reports pass/fail, mismatch count and the first failing operands.
// Optional feature: define GATE_BIST_SIGNATURE_EN to add a 16-bit MISR over dut_y.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH-1:0]   dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
`ifdef GATE_BIST_SIGNATURE_EN
    ,
    output logic [15:0]        signature
`endif
);

    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [IW-1:0] IDX_LAST = '1;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [EW-1:0]    err_q, err_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [WIDTH-1:0] exp_y;
    logic             mism;
`ifdef GATE_BIST_SIGNATURE_EN
    logic [15:0]      sig_q, sig_d;
`endif

    gate_ref #(.WIDTH(WIDTH)) u_ref (
        .op  (op_q),
        .a   (idx_q[IW-1:WIDTH]),
        .b   (idx_q[WIDTH-1:0]),
        .exp (exp_y)
    );

    assign mism = (dut_y != exp_y);

    // Next-state and datapath updates for the IDLE/DRIVE/SAMPLE/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
`ifdef GATE_BIST_SIGNATURE_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = CW'(1);
                    op_d    = op;
                    err_d   = '0;
                    fa_d    = '0;
                    fb_d    = '0;
`ifdef GATE_BIST_SIGNATURE_EN
                    sig_d   = MISR_SEED;
`endif
                end
            end
            ST_DRIVE: begin
                // Hold the vector until the gate output has had SETTLE cycles.
                if (cnt_q == SETTLE_C) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SAMPLE: begin
                if (mism) begin
                    err_d = err_q + EW'(1);
                    // err_q still zero means this is the first failing vector.
                    if (err_q == '0) begin
                        fa_d = idx_q[IW-1:WIDTH];
                        fb_d = idx_q[WIDTH-1:0];
                    end
                end
`ifdef GATE_BIST_SIGNATURE_EN
                sig_d = misr_step(sig_q, {{(16-WIDTH){1'b0}}, dut_y});
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = CW'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any run and discards partial results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            err_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
`ifdef GATE_BIST_SIGNATURE_EN
            sig_q   <= MISR_SEED;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
`ifdef GATE_BIST_SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign dut_a     = idx_q[IW-1:WIDTH];
    assign dut_b     = idx_q[WIDTH-1:0];
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
`ifdef GATE_BIST_SIGNATURE_EN
    assign signature = sig_q;
`endif

endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test sequencer for the two-input gate primitives that make up the integer ALU (nand_gate and its siblings). It sits directly around a gate under test. It drives that gate's `a`/`b` inputs with an exhaustive vector sequence and consumes the gate's output. It compares each result against a reference function chosen by opcode, then reports pass/fail, an error count and the first failing vector. It replaces hand-written per-gate truth-table benches with one reusable, synthesizable checker.

## Interface
Parameters:
- `WIDTH`, default 1: operand width of the gate under test (bitwise gate); legal 1..8.
- `SETTLE`, default 1: cycles a vector is held before sampling; legal ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a run; accepted only when `busy`=0.
- `op`  in  3: expected function. 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT-A, 7 BUF-A. Captured on accepted `start`.
- `dut_a`  out  WIDTH: operand A to gate under test.
- `dut_b`  out  WIDTH: operand B to gate under test.
- `dut_y`  in  WIDTH: gate under test output.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; held until next accepted `start` or `rst`.
- `pass`  out  1: valid while `done`=1; 1 iff `err_count`=0.
- `err_count`  out  2*WIDTH+1: number of mismatching vectors.
- `fail_a`, `fail_b`  out  WIDTH each: operands of the first mismatching vector.
- `signature`  out  16: only with `GATE_BIST_SIGNATURE_EN` (see Configuration).

## Operation
- N = 2^(2*WIDTH) vectors. Index `idx` is 2*WIDTH bits wide. `dut_a`=idx[2W-1:W] and `dut_b`=idx[W-1:0`], so for W=1 the order is 00, 01, 10, 11.
- Reference `exp` is the bitwise `op` function of `dut_a`, `dut_b`. A mismatch is `dut_y` != `exp` on any bit, and counts once per vector.
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
  - IDLE: start→DRIVE. Load idx=0, clear err_count, fail_a, fail_b and done, and latch op.
  - DRIVE: hold vector; wait counter runs 1..SETTLE; at SETTLE→SAMPLE.
  - SAMPLE: compare once. On mismatch, increment err_count. On the first mismatch only, latch fail_a/fail_b. If idx=N-1→DONE, else idx+1→DRIVE.
  - DONE: done=1; start→DRIVE (fresh run, same as from IDLE).
- `start` while busy is ignored. Reaching DONE does not change `op` or the outputs.
- Reset values: state IDLE, dut_a=dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_a=fail_b=0.
- `rst` mid-run aborts immediately to the reset values. No partial results are retained.
- `pass` = done & (err_count==0). It is never 1 outside DONE.
- err_count max is N, which fits in 2*WIDTH+1 bits, so no saturation is needed.

## Timing
- Edge 0 samples `start`=1 and enters DRIVE with idx=0. `busy`=1 from that edge.
- Each vector occupies SETTLE+1 cycles (SETTLE in DRIVE plus 1 in SAMPLE). `dut_a`/`dut_b` are registered and stable for the whole window.
- The compare uses `dut_y` as sampled at the SAMPLE-state edge. The gate under test is combinational, with a path ≤ SETTLE cycles.
- `done` rises, and `busy` falls, at edge N*(SETTLE+1). err_count, fail_a/fail_b and signature are final on that same edge.
- For W=1 and SETTLE=1: done at edge 8.

## Configuration
- `GATE_BIST_SIGNATURE_EN` defined: adds the `signature` port with a 16-bit MISR.
  - Reset value and per-start value: 16'hFFFF.
  - Each SAMPLE: sig ← {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended dut_y.
- Undefined: no `signature` port and no MISR logic. All other behaviour is identical.

## Structure
- `gate_bist_pkg`: the `op` encoding localparams (OP_AND … OP_BUF), the FSM state enum, and the MISR polynomial constant 16'h1021.
- One sub-module, `gate_ref`: combinational `op`, `a`, `b` → `exp`, parameterized by WIDTH. It is reusable by ALU benches.

## Test plan
- W=1, SETTLE=1, op=NAND, correct nand_gate → dut_a/dut_b walk 00, 01, 10, 11; done at edge 8; pass=1, err_count=0.
- Same, but dut_y stuck-at-0 → err_count=3, fail_a=0, fail_b=0, pass=0.
- W=2, SETTLE=2, op=XOR, correct XOR → 16 vectors; done at edge 48; pass=1.
- `start` pulsed at edge 3 of a run → ignored; done still at edge 8 and the result is unchanged.
- `rst` asserted at edge 5 → next edge has busy=0, done=0, err_count=0, dut_a=dut_b=0. A subsequent start completes normally.
- With `GATE_BIST_SIGNATURE_EN`: two runs with a correct NAND give identical signatures. A stuck-at-0 run gives a different signature.
